// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
// Address arithmetic wraps at the register count.
package reg_dump_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  // Next register address; the 5-bit width provides the 31 -> 0 wrap.
  function automatic logic [ADDR_W-1:0] next_index(input logic [ADDR_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/reg_dump_reader_if.sv
// Request, register-file read port and output stream of the dump reader.
// The master modport is the reader; the slave modport is its environment.
interface reg_dump_reader_if;
  import reg_dump_pkg::*;

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] ReadRegister;
  logic [DATA_W-1:0] ReadData;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  modport master (
    input  start, abort, first_reg, last_reg, ReadData, out_ready,
    output ReadRegister, out_valid, out_data, out_index, out_last,
           busy, done, checksum
  );

  modport slave (
    output start, abort, first_reg, last_reg, ReadData, out_ready,
    input  ReadRegister, out_valid, out_data, out_index, out_last,
           busy, done, checksum
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Walks a wrapping range of register addresses through one read port and
// streams each captured word out with its index and a running checksum.
module reg_dump_reader
  import reg_dump_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  reg_dump_reader_if.master bus
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] index_reg, index_next;
  logic [ADDR_W-1:0] end_reg, end_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic [ADDR_W-1:0] out_index_reg, out_index_next;
  logic              out_last_reg, out_last_next;
  logic [DATA_W-1:0] checksum_reg, checksum_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      index_reg     <= '0;
      end_reg       <= '0;
      out_data_reg  <= '0;
      out_index_reg <= '0;
      out_last_reg  <= 1'b0;
      checksum_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      end_reg       <= end_next;
      out_data_reg  <= out_data_next;
      out_index_reg <= out_index_next;
      out_last_reg  <= out_last_next;
      checksum_reg  <= checksum_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    index_next     = index_reg;
    end_next       = end_reg;
    out_data_next  = out_data_reg;
    out_index_next = out_index_reg;
    out_last_next  = out_last_reg;
    checksum_next  = checksum_reg;

    case (state_reg)
      IDLE: begin
        // start beats a simultaneous abort here because abort is not examined
        if (bus.start) begin
          index_next    = bus.first_reg;
          end_next      = bus.last_reg;
          checksum_next = '0;
          state_next    = READ;
        end
      end
      READ: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else begin
          out_data_next  = bus.ReadData;
          out_index_next = index_reg;
          out_last_next  = (index_reg == end_reg);
          state_next     = SEND;
        end
      end
      SEND: begin
        // abort wins over a handshake in the same cycle
        if (bus.abort) begin
          state_next = IDLE;
        end else if (bus.out_ready) begin
          checksum_next = checksum_reg + out_data_reg;
          if (out_last_reg) begin
            state_next = DONE;
          end else begin
            index_next = next_index(index_reg);
            state_next = READ;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.ReadRegister = index_reg;
  assign bus.out_valid    = (state_reg == SEND);
  assign bus.out_data     = out_data_reg;
  assign bus.out_index    = out_index_reg;
  assign bus.out_last     = out_last_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.done         = (state_reg == DONE);
  assign bus.checksum     = checksum_reg;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a register-file model feeds the read
// port, expected words go to a scoreboard queue and are popped on handshakes.
module tb_reg_dump_reader;
  import reg_dump_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_dump_reader_if bus ();

  reg_dump_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] regs [NUM_REGS];
  assign bus.ReadData = regs[bus.ReadRegister];

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t        sb[$];
  exp_t        prev_word;
  logic        prev_stall = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          done_count = 0;
  logic [31:0] exp_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples the DUT at the falling edge, then returns just after the next rising edge.
  task automatic tick(output bit done_seen);
    exp_t e;
    @(negedge clk);
    done_seen = 1'b0;
    if (reset) begin
      if (bus.done) done_count++;
      done_seen = bus.done;
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_data", bus.out_data, prev_word.data);
        check("stall_index", bus.out_index, prev_word.idx);
        check("stall_last", bus.out_last, prev_word.last);
      end
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        check("sb_has_entry", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          $display("word idx=%0d data=%08h last=%0b", bus.out_index, bus.out_data, bus.out_last);
          check("word_index", bus.out_index, e.idx);
          check("word_data", bus.out_data, e.data);
          check("word_last", bus.out_last, e.last);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready && !bus.abort;
      prev_word  = '{idx: bus.out_index, data: bus.out_data, last: bus.out_last};
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [ADDR_W-1:0] first, input logic [ADDR_W-1:0] last);
    logic [ADDR_W-1:0] diff;
    logic [ADDR_W-1:0] a;
    int n;
    exp_t e;
    diff = last - first;
    n = int'(diff) + 1;
    exp_sum = '0;
    for (int j = 0; j < n; j++) begin
      a = first + ADDR_W'(j);
      e = '{idx: a, data: regs[a], last: (j == n - 1)};
      exp_sum = exp_sum + regs[a];
      sb.push_back(e);
    end
  endtask

  task automatic run_dump(input logic [ADDR_W-1:0] first, input logic [ADDR_W-1:0] last,
                          input bit rnd, output int cyc);
    bit d;
    int dc0;
    push_expected(first, last);
    bus.first_reg = first;
    bus.last_reg  = last;
    bus.start     = 1'b1;
    tick(d);
    bus.start = 1'b0;
    dc0 = done_count;
    cyc = 0;
    d = 1'b0;
    for (int i = 0; i < 400 && !d; i++) begin
      tick(d);
      cyc++;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    end
    bus.out_ready = 1'b1;
    $display("dump %0d..%0d cycles=%0d checksum=%08h", first, last, cyc, bus.checksum);
    check("dump_done_seen", d, 1'b1);
    check("dump_checksum", bus.checksum, exp_sum);
    check("dump_done_once", done_count, dc0 + 1);
    check("dump_sb_empty", sb.size(), 0);
    check("dump_idle_busy", bus.busy, 1'b0);
  endtask

  task automatic wait_valid(input logic [ADDR_W-1:0] idx);
    bit d;
    bit hit;
    hit = bus.out_valid && bus.out_index == idx;
    for (int i = 0; i < 50 && !hit; i++) begin
      tick(d);
      hit = bus.out_valid && bus.out_index == idx;
    end
    check("wait_valid", hit, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ReadRegister"}, bus.ReadRegister, '0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"}, bus.out_data, '0);
    check({tag, "_out_index"}, bus.out_index, '0);
    check({tag, "_out_last"}, bus.out_last, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_checksum"}, bus.checksum, '0);
  endtask

  initial begin
    bit d;
    int cyc;
    int dc0;
    logic [31:0] sum_ready1;
    logic [31:0] partial;

    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.first_reg = '0;
    bus.last_reg  = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) regs[k] = 32'h100 + k;

    repeat (3) tick(d);
    check_reset_outputs("reset");
    reset = 1'b1;
    tick(d);

    // Full range: 32 words, done in cycle 65 after start
    run_dump(5'd0, 5'd31, 1'b0, cyc);
    check("full_cycles", cyc, 65);
    check("full_checksum_const", bus.checksum, 32'h21F0);

    // Wrapping range 30..1
    run_dump(5'd30, 5'd1, 1'b0, cyc);
    check("wrap_cycles", cyc, 9);

    // Single word
    regs[16] = 32'd20;
    run_dump(5'd16, 5'd16, 1'b0, cyc);
    check("single_cycles", cyc, 3);
    check("single_checksum", bus.checksum, 32'd20);

    // Back-pressure must not change sequence or checksum
    run_dump(5'd4, 5'd7, 1'b0, cyc);
    sum_ready1 = bus.checksum;
    bus.out_ready = 1'b0;
    run_dump(5'd4, 5'd7, 1'b1, cyc);
    check("bp_checksum_same", bus.checksum, sum_ready1);

    // Abort during SEND of the third word, with a handshake offered at once
    bus.out_ready = 1'b0;
    push_expected(5'd0, 5'd9);
    partial = regs[0] + regs[1];
    bus.first_reg = 5'd0;
    bus.last_reg  = 5'd9;
    bus.start     = 1'b1;
    tick(d);
    bus.start = 1'b0;
    dc0 = done_count;
    for (int w = 0; w < 2; w++) begin
      wait_valid(ADDR_W'(w));
      bus.out_ready = 1'b1;
      tick(d);
      bus.out_ready = 1'b0;
    end
    wait_valid(5'd2);
    bus.abort     = 1'b1;
    bus.out_ready = 1'b1;
    tick(d);
    bus.abort = 1'b0;
    $display("abort valid=%0b busy=%0b checksum=%08h", bus.out_valid, bus.busy, bus.checksum);
    check("abort_valid", bus.out_valid, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_checksum", bus.checksum, partial);
    check("abort_sb_left", sb.size(), 8);
    sb.delete();
    tick(d);
    tick(d);
    check("abort_no_done", done_count, dc0);
    run_dump(5'd2, 5'd3, 1'b0, cyc);

    // Reset asserted while in READ
    bus.first_reg = 5'd0;
    bus.last_reg  = 5'd5;
    bus.start     = 1'b1;
    tick(d);
    bus.start = 1'b0;
    check("pre_reset_busy", bus.busy, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    dc0 = done_count;
    tick(d);
    tick(d);
    reset = 1'b1;
    tick(d);
    tick(d);
    check("post_reset_idle", bus.busy, 1'b0);
    check("post_reset_no_done", done_count, dc0);
    run_dump(5'd0, 5'd0, 1'b0, cyc);
    check("post_reset_cycles", cyc, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
